// File: rtl/collision_event_queue.sv
// collision_event_queue
//   Watches the collision flag bus. On each scan_done it snapshots the flags and
//   finds flags that went 0->1 since the previous snapshot. It then walks the
//   indices one per cycle and queues {scan tag, index} events in a small
//   first-word-fall-through FIFO that the CPU pops one entry at a time.
// Ports
//   clk, reset      clock, synchronous active-high reset
//   flags           collision flag bus
//   scan_done       1-cycle pulse: flags are valid
//   rd_en           pop the head entry (ignored when empty)
//   clr_overflow    clear the overflow and missed_scan sticky bits
//   rd_data         head entry {tag, index}, 0 when empty
//   empty/full      FIFO status
//   count           number of entries held
//   busy            a snapshot is being scanned
//   overflow        sticky: an event was dropped because the FIFO was full
//   missed_scan     sticky: a scan_done was dropped (pending slot in use)
//   irq             registered !empty
module collision_event_queue #(
  parameter int unsigned NUM_FLAGS  = 30,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned TAG_W      = 3,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_FLAGS-1:0]   flags,
  input  logic                   scan_done,
  input  logic                   rd_en,
  input  logic                   clr_overflow,
  output logic [TAG_W+IDX_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [DEPTH_LOG2:0]    count,
  output logic                   busy,
  output logic                   overflow,
  output logic                   missed_scan,
  output logic                   irq
);

  localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
  localparam int unsigned ENTRY_W = TAG_W + IDX_W;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_FLAGS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [TAG_W-1:0]      TAG_ONE  = TAG_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_FLAGS-1:0]    new_q;
  logic [NUM_FLAGS-1:0]    prev_q;
  logic [NUM_FLAGS-1:0]    pend_snap_q;
  logic                    pending_q;
  logic [TAG_W-1:0]        tag_q;

  logic [ENTRY_W-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q;
  logic [DEPTH_LOG2:0]     count_q;
  logic [DEPTH_LOG2:0]     count_d;
  logic                    empty_q;
  logic                    full_q;
  logic                    irq_q;
  logic                    overflow_q;
  logic                    missed_q;

  logic                    pop;
  logic                    push_req;
  logic                    push_ok;
  logic                    ovf_set;
  logic                    miss_set;
  logic                    start;
  logic [NUM_FLAGS-1:0]    snap_src;

  always_comb begin
    pop      = rd_en && !empty_q;
    // new_q is shifted right during the scan, so bit 0 is always the current index
    push_req = (state_q == SCAN) && new_q[0];
    // a same-cycle pop frees the slot, so a full FIFO can still accept
    push_ok  = push_req && (!full_q || pop);
    ovf_set  = push_req && !push_ok;
    miss_set = (state_q == SCAN) && scan_done && pending_q;
    start    = (state_q == IDLE) && (pending_q || scan_done);
    snap_src = pending_q ? pend_snap_q : flags;
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      new_q       <= '0;
      prev_q      <= '0;
      pend_snap_q <= '0;
      pending_q   <= 1'b0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      irq_q       <= 1'b0;
      overflow_q  <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {tag_q, idx_q};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == CNT_FULL);
      irq_q      <= (count_d != '0);
      // set has priority over clear
      overflow_q <= ovf_set  | (overflow_q & ~clr_overflow);
      missed_q   <= miss_set | (missed_q   & ~clr_overflow);

      case (state_q)
        IDLE: begin
          if (start) begin
            new_q   <= snap_src & ~prev_q;
            prev_q  <= snap_src;
            tag_q   <= tag_q + TAG_ONE;
            idx_q   <= '0;
            state_q <= SCAN;
            // a pulse arriving while the pending snapshot launches refills the slot
            if (pending_q && scan_done) begin
              pend_snap_q <= flags;
            end else begin
              pending_q <= 1'b0;
            end
          end
        end
        SCAN: begin
          new_q <= new_q >> 1;
          idx_q <= idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
          end
          if (scan_done && !pending_q) begin
            pend_snap_q <= flags;
            pending_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data     = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty       = empty_q;
  assign full        = full_q;
  assign count       = count_q;
  assign busy        = (state_q == SCAN);
  assign overflow    = overflow_q;
  assign missed_scan = missed_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_collision_event_queue.sv
module tb_collision_event_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] flags;
  logic        scan_done;
  logic        rd_en;
  logic        clr_overflow;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        busy;
  logic        overflow;
  logic        missed_scan;
  logic        irq;

  int total = 0;
  int bad   = 0;

  collision_event_queue #(
    .NUM_FLAGS (30),
    .IDX_W     (5),
    .TAG_W     (3),
    .DEPTH_LOG2(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flags       (flags),
    .scan_done   (scan_done),
    .rd_en       (rd_en),
    .clr_overflow(clr_overflow),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .busy        (busy),
    .overflow    (overflow),
    .missed_scan (missed_scan),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Each scan is described by its start edge; every newly-set index i is
  // scheduled to enter the queue at start+i+1, and the scan is busy for
  // 30 edges after its start.
  typedef struct {
    int         t;
    logic [7:0] d;
  } ev_t;

  logic [7:0]  mq [$];
  ev_t         sched [$];
  int          cyc = 0;
  int          scan_end = -1;
  logic        m_pend = 1'b0;
  logic [29:0] m_pend_snap = '0;
  logic [29:0] m_prev = '0;
  logic [2:0]  m_tag = '0;
  logic        m_ovf = 1'b0;
  logic        m_miss = 1'b0;
  logic        started = 1'b0;

  logic        do_pop, was_busy, ovf_set, miss_set;
  ev_t         ev;

  task automatic start_scan(input logic [29:0] snap);
    logic [29:0] nw;
    nw       = snap & ~m_prev;
    m_prev   = snap;
    m_tag    = m_tag + 3'd1;
    scan_end = cyc + 30;
    for (int i = 0; i < 30; i++) begin
      if (nw[i]) sched.push_back('{t: cyc + i + 1, d: {m_tag, 5'(i)}});
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      started = 1'b1;
      mq.delete();
      sched.delete();
      scan_end    = -1;
      m_pend      = 1'b0;
      m_pend_snap = '0;
      m_prev      = '0;
      m_tag       = '0;
      m_ovf       = 1'b0;
      m_miss      = 1'b0;
    end else begin
      ovf_set  = 1'b0;
      miss_set = 1'b0;
      do_pop   = rd_en && (mq.size() > 0);
      was_busy = (cyc <= scan_end);
      if (do_pop) void'(mq.pop_front());
      if (sched.size() > 0 && sched[0].t == cyc) begin
        ev = sched.pop_front();
        if (mq.size() < 8) mq.push_back(ev.d);
        else ovf_set = 1'b1;
      end
      if (was_busy) begin
        if (scan_done) begin
          if (m_pend) miss_set = 1'b1;
          else begin
            m_pend      = 1'b1;
            m_pend_snap = flags;
          end
        end
      end else if (m_pend) begin
        start_scan(m_pend_snap);
        if (scan_done) m_pend_snap = flags;
        else m_pend = 1'b0;
      end else if (scan_done) begin
        start_scan(flags);
      end
      m_ovf  = ovf_set  | (m_ovf  & ~clr_overflow);
      m_miss = miss_set | (m_miss & ~clr_overflow);
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("rd_data",  32'(rd_data),     (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      chk("count",    32'(count),       32'(mq.size()));
      chk("empty",    32'(empty),       32'(mq.size() == 0));
      chk("full",     32'(full),        32'(mq.size() == 8));
      chk("irq",      32'(irq),         32'(mq.size() != 0));
      chk("busy",     32'(busy),        32'(cyc < scan_end));
      chk("overflow", 32'(overflow),    32'(m_ovf));
      chk("missed",   32'(missed_scan), 32'(m_miss));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_scan(input logic [29:0] f);
    flags     = f;
    scan_done = 1'b1;
    tick();
    scan_done = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  int busy_cycles;
  logic [7:0] exp4 [10];

  initial begin
    reset = 1'b0; flags = '0; scan_done = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;
    tick();
    do_reset();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_rd",    32'(rd_data), 32'd0);

    // 1: two new flags
    pulse_scan(30'h0000_0005);
    busy_cycles = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy) busy_cycles++;
      tick();
    end
    chk("t1_busy_len", 32'(busy_cycles), 32'd30);
    chk("t1_count",    32'(count),   32'd2);
    chk("t1_head0",    32'(rd_data), 32'h20);
    pop_one();
    chk("t1_head1",    32'(rd_data), 32'h22);
    pop_one();
    chk("t1_empty",    32'(empty),   32'd1);

    // 2: unchanged flags give nothing; re-arm by falling to 0
    pulse_scan(30'h0000_0005);
    repeat (32) tick();
    chk("t2_noevt", 32'(count), 32'd0);
    pulse_scan(30'h0);
    repeat (32) tick();
    pulse_scan(30'h1);
    repeat (32) tick();
    chk("t2_tag4", 32'(rd_data), 32'h80);
    pop_one();

    // 3: ten new flags, no reads
    do_reset();
    pulse_scan(30'h3FF);
    repeat (32) tick();
    chk("t3_count", 32'(count),    32'd8);
    chk("t3_full",  32'(full),     32'd1);
    chk("t3_ovf",   32'(overflow), 32'd1);
    chk("t3_head",  32'(rd_data),  32'h20);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t3_clr",   32'(overflow), 32'd0);

    // 4: full FIFO, pop during each push
    pulse_scan(30'hFFF);
    repeat (10) tick();
    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    chk("t4_count", 32'(count),    32'd8);
    chk("t4_ovf",   32'(overflow), 32'd0);
    repeat (20) tick();
    exp4 = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h4A, 8'h4B, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      chk("t4_order", 32'(rd_data), 32'(exp4[i]));
      pop_one();
    end
    chk("t4_empty", 32'(empty), 32'd1);

    // 5: pending and missed scans
    do_reset();
    pulse_scan(30'h1);
    repeat (4) tick();
    pulse_scan(30'h2);
    repeat (4) tick();
    pulse_scan(30'h4);
    chk("t5_missed", 32'(missed_scan), 32'd1);
    repeat (70) tick();
    chk("t5_count", 32'(count),   32'd2);
    chk("t5_head0", 32'(rd_data), 32'h20);
    pop_one();
    chk("t5_head1", 32'(rd_data), 32'h41);
    pop_one();
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t5_clr", 32'(missed_scan), 32'd0);

    // 6: reset in the middle of a scan
    do_reset();
    pulse_scan(30'h3FFF_FFFF);
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_busy",  32'(busy),  32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_irq",   32'(irq),   32'd0);

    // randomized traffic against the model
    flags = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) flags = flags ^ (30'(1) << $urandom_range(0, 29));
      if ($urandom_range(0, 7) == 0) flags = flags & 30'($urandom);
      scan_done    = ($urandom_range(0, 14) == 0);
      rd_en        = ($urandom_range(0, 3) == 0);
      clr_overflow = ($urandom_range(0, 40) == 0);
      reset        = ($urandom_range(0, 1500) == 0);
      tick();
    end
    reset = 1'b0; scan_done = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
